mdio_master: RTL and testbench
==============================

MDIO_MASTER -- requirements
Module: mdio_master

Interface
REQ-001 Parameter CLK_DIV, default 40, meaning clk_100_mhz cycles per MDC period; SHALL be even and >=4 (40 gives 2.5 MHz MDC).
REQ-002 Parameter PREAMBLE_LEN, default 32, meaning number of preamble '1' bits per frame; SHALL be 0..32.
REQ-003 Port clk_100_mhz  input  1  the single clock for all logic.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port start  input  1  request a transaction; sampled only while busy=0.
REQ-006 Port mode_i  input  1  0=write, 1=read.
REQ-007 Port addr_i  input  5  PHY address.
REQ-008 Port reg_addr_i  input  5  register address.
REQ-009 Port data_i  input  16  write data.
REQ-010 Port data_o  output  16  last successful read data.
REQ-011 Port busy  output  1  transaction in progress.
REQ-012 Port done  output  1  single-cycle completion pulse.
REQ-013 Port rd_err  output  1  last read had no PHY turnaround response.
REQ-014 Port mdc  output  1  management clock.
REQ-015 Ports mdio_o, mdio_oe (output, 1 each) and mdio_i (input, 1) form a split tristate; the pad buffer lives outside this block.

Function
REQ-016 Frame is Clause 22, MSB first: PREAMBLE_LEN '1's, ST=01, OP (01 write / 10 read), PHYAD[4:0], REGAD[4:0], TA, DATA[15:0], then one idle bit with mdio_oe=0.
REQ-017 States SHALL be IDLE, PRE, ST, OP, PHY, REG, TA, DATA, END. PRE is skipped when PREAMBLE_LEN=0. A 5-bit counter indexes bits within each state.
REQ-018 In IDLE with start=1: latch mode_i/addr_i/reg_addr_i/data_i, and assert busy on the next edge. start while busy=1 SHALL be ignored.
REQ-019 mdc SHALL be 0 in IDLE. During a transaction mdc is low for CLK_DIV/2 cycles, then high for CLK_DIV/2 cycles, per bit.
REQ-020 mdio_o/mdio_oe SHALL change only on the clock edge that drives mdc 1->0, or at the first bit of the frame. mdio_i SHALL be sampled on the edge that drives mdc 0->1.
REQ-021 Write TA SHALL drive 1 then 0 with mdio_oe=1. Read TA and read DATA SHALL hold mdio_oe=0.
REQ-022 Read: if the second TA bit samples 1, rd_err SHALL be set and data_o SHALL hold its value. Otherwise rd_err is cleared and data_o is loaded with the 16 sampled bits when done pulses.
REQ-023 Write SHALL clear rd_err at done and leave data_o unchanged.
REQ-024 done SHALL pulse exactly (PREAMBLE_LEN+33)*CLK_DIV cycles after the start-accepting edge. busy SHALL drop on the same edge, and the FSM returns to IDLE; start may be accepted on the following cycle.
REQ-025 Bit counter and divider widths SHALL hold CLK_DIV-1 and 31 without overflow, and wrap to 0 at each bit/state boundary.

Reset
REQ-026 rst_n=0 SHALL immediately force state=IDLE, mdc=0, mdio_o=1, mdio_oe=0, busy=0, done=0, rd_err=0, data_o=16'h0000. The divider and bit counters are zeroed, including mid-frame.
REQ-027 After rst_n deasserts, no transaction SHALL start until start is sampled high.

Verification (CLK_DIV=4, PREAMBLE_LEN=32 unless stated)
REQ-028 Write: addr 1, reg 0, data 0x1200 -> mdio_o serial = 32x'1', 01 01 00001 00000 10 0001001000000000, mdio_oe=1 throughout the frame; done at cycle 260; data_o unchanged.
REQ-029 Read: addr 1, reg 1; the PHY model drives TA2=0 then 0x796D on mdc falling edges -> mdio_oe=0 from TA1 through the idle bit; data_o=0x796D, rd_err=0 at done (cycle 260).
REQ-030 Read with mdio_i held at 1 (no PHY) -> rd_err=1 at done; data_o stays 0x796D.
REQ-031 start pulsed again at cycle 50 with addr 7 -> ignored; frame bits unchanged; exactly one done.
REQ-032 rst_n low during DATA bit 5 -> same cycle: mdc=0, mdio_oe=0, busy=0, data_o=0; a subsequent write completes a full 260-cycle frame.
REQ-033 PREAMBLE_LEN=0 write -> first mdio_o bits are 01 (no preamble); done at cycle 132.

Source files
------------

// File: rtl/mdio_master_if.sv
// Host-side and pin-side signals of the MDIO master, grouped for port use.
`timescale 1ns/1ps
interface mdio_master_if;
    logic        start;
    logic        mode_i;
    logic [4:0]  addr_i;
    logic [4:0]  reg_addr_i;
    logic [15:0] data_i;
    logic [15:0] data_o;
    logic        busy;
    logic        done;
    logic        rd_err;
    logic        mdc;
    logic        mdio_o;
    logic        mdio_oe;
    logic        mdio_i;

    // Requester side: issues transactions and models the PHY's mdio_i.
    modport master (
        output start, mode_i, addr_i, reg_addr_i, data_i, mdio_i,
        input  data_o, busy, done, rd_err, mdc, mdio_o, mdio_oe
    );

    // Block side: the mdio_master itself.
    modport slave (
        input  start, mode_i, addr_i, reg_addr_i, data_i, mdio_i,
        output data_o, busy, done, rd_err, mdc, mdio_o, mdio_oe
    );
endinterface

// File: rtl/mdio_master.sv
// Clause 22 MDIO management master: serialises one read or write frame
// per accepted start, generating mdc from the system clock.
`timescale 1ns/1ps
module mdio_master #(
    parameter int CLK_DIV      = 40,
    parameter int PREAMBLE_LEN = 32
) (
    input  logic          clk_100_mhz,
    input  logic          rst_n,
    mdio_master_if.slave  bus
);
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV/2 - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [4:0] PRE_LAST = 5'((PREAMBLE_LEN > 0) ? PREAMBLE_LEN - 1 : 0);

    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_PRE  = 4'd1;
    localparam logic [3:0] S_ST   = 4'd2;
    localparam logic [3:0] S_OP   = 4'd3;
    localparam logic [3:0] S_PHY  = 4'd4;
    localparam logic [3:0] S_REG  = 4'd5;
    localparam logic [3:0] S_TA   = 4'd6;
    localparam logic [3:0] S_DATA = 4'd7;
    localparam logic [3:0] S_END  = 4'd8;
    localparam logic [3:0] S_FIRST = (PREAMBLE_LEN > 0) ? S_PRE : S_ST;

    logic [3:0]       state, nxt_state;
    logic [4:0]       cnt, nxt_cnt;
    logic [DIV_W-1:0] div;
    logic             lat_mode;
    logic [4:0]       lat_phy, lat_reg;
    logic [15:0]      lat_data, shreg, data_q;
    logic             ta_err;
    logic             mdc_q, mdio_o_q, mdio_oe_q, busy_q, done_q, rd_err_q;

    assign bus.mdc     = mdc_q;
    assign bus.mdio_o  = mdio_o_q;
    assign bus.mdio_oe = mdio_oe_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.rd_err  = rd_err_q;
    assign bus.data_o  = data_q;

    // {oe, o} to present for bit c of state st; idle/end release the line.
    function automatic logic [1:0] frame_bit(input logic [3:0] st, input logic [3:0] c,
                                             input logic rd, input logic [4:0] phy,
                                             input logic [4:0] reg_a, input logic [15:0] d);
        logic [1:0] r;
        case (st)
            S_PRE:   r = 2'b11;
            S_ST:    r = {1'b1, c[0]};
            S_OP:    r = {1'b1, rd ^ c[0]};
            S_PHY:   r = {1'b1, phy[3'd4 - c[2:0]]};
            S_REG:   r = {1'b1, reg_a[3'd4 - c[2:0]]};
            S_TA:    r = rd ? 2'b01 : {1'b1, ~c[0]};
            S_DATA:  r = rd ? 2'b01 : {1'b1, d[4'd15 - c[3:0]]};
            default: r = 2'b01;
        endcase
        return r;
    endfunction

    // Field sequencing applied at each bit boundary.
    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt + 5'd1;
        case (state)
            S_PRE:  if (cnt == PRE_LAST) begin nxt_state = S_ST;   nxt_cnt = '0; end
            S_ST:   if (cnt == 5'd1)     begin nxt_state = S_OP;   nxt_cnt = '0; end
            S_OP:   if (cnt == 5'd1)     begin nxt_state = S_PHY;  nxt_cnt = '0; end
            S_PHY:  if (cnt == 5'd4)     begin nxt_state = S_REG;  nxt_cnt = '0; end
            S_REG:  if (cnt == 5'd4)     begin nxt_state = S_TA;   nxt_cnt = '0; end
            S_TA:   if (cnt == 5'd1)     begin nxt_state = S_DATA; nxt_cnt = '0; end
            S_DATA: if (cnt == 5'd15)    begin nxt_state = S_END;  nxt_cnt = '0; end
            default: begin nxt_state = S_IDLE; nxt_cnt = '0; end
        endcase
    end

    // Divider, FSM, pin drive, read sampling and completion reporting.
    always_ff @(posedge clk_100_mhz or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            div       <= '0;
            lat_mode  <= 1'b0;
            lat_phy   <= '0;
            lat_reg   <= '0;
            lat_data  <= '0;
            shreg     <= '0;
            ta_err    <= 1'b0;
            mdc_q     <= 1'b0;
            mdio_o_q  <= 1'b1;
            mdio_oe_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_err_q  <= 1'b0;
            data_q    <= '0;
        end else begin
            done_q <= 1'b0;
            if (state == S_IDLE) begin
                mdc_q <= 1'b0;
                div   <= '0;
                cnt   <= '0;
                if (bus.start) begin
                    state    <= S_FIRST;
                    busy_q   <= 1'b1;
                    lat_mode <= bus.mode_i;
                    lat_phy  <= bus.addr_i;
                    lat_reg  <= bus.reg_addr_i;
                    lat_data <= bus.data_i;
                    ta_err   <= 1'b0;
                    // First bit comes straight from the ports; the latches are not yet loaded.
                    {mdio_oe_q, mdio_o_q} <= frame_bit(S_FIRST, 4'd0, bus.mode_i, bus.addr_i,
                                                       bus.reg_addr_i, bus.data_i);
                end
            end else begin
                div <= div + 1'b1;
                if (div == DIV_HALF) begin
                    mdc_q <= 1'b1;
                    if (lat_mode && state == S_TA && cnt == 5'd1)
                        ta_err <= bus.mdio_i;
                    if (lat_mode && state == S_DATA)
                        shreg <= {shreg[14:0], bus.mdio_i};
                end
                if (div == DIV_LAST) begin
                    div   <= '0;
                    mdc_q <= 1'b0;
                    state <= nxt_state;
                    cnt   <= nxt_cnt;
                    {mdio_oe_q, mdio_o_q} <= frame_bit(nxt_state, nxt_cnt[3:0], lat_mode,
                                                       lat_phy, lat_reg, lat_data);
                    if (state == S_END) begin
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        if (lat_mode && ta_err) begin
                            rd_err_q <= 1'b1;
                        end else begin
                            rd_err_q <= 1'b0;
                            if (lat_mode)
                                data_q <= shreg;
                        end
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_mdio_master.sv
// Self-checking bench for mdio_master: frames are predicted bit by bit from
// the Clause 22 layout and compared cycle by cycle on two instances
// (32-bit preamble and no preamble).
`timescale 1ns/1ps
module tb_mdio_master;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, sel0, mode, mdio_i;
    logic [4:0]  addr, rega;
    logic [15:0] wdata;

    int          errors = 0;
    int          checks = 0;
    logic [15:0] model_data;
    logic        model_err;

    always #5 clk = ~clk;

    mdio_master_if bus ();
    mdio_master_if bus0 ();

    assign bus.start       = start & ~sel0;
    assign bus.mode_i      = mode;
    assign bus.addr_i      = addr;
    assign bus.reg_addr_i  = rega;
    assign bus.data_i      = wdata;
    assign bus.mdio_i      = mdio_i;
    assign bus0.start      = start & sel0;
    assign bus0.mode_i     = mode;
    assign bus0.addr_i     = addr;
    assign bus0.reg_addr_i = rega;
    assign bus0.data_i     = wdata;
    assign bus0.mdio_i     = mdio_i;

    mdio_master #(.CLK_DIV(D), .PREAMBLE_LEN(32)) dut (
        .clk_100_mhz(clk), .rst_n(rst_n), .bus(bus)
    );
    mdio_master #(.CLK_DIV(D), .PREAMBLE_LEN(0)) dut0 (
        .clk_100_mhz(clk), .rst_n(rst_n), .bus(bus0)
    );

    // Runs one frame from start to done and checks every cycle against the
    // frame layout; phy=1 makes the PHY model answer reads with d.
    task automatic run_frame(input bit p0, input bit rd, input logic [4:0] a,
                             input logic [4:0] r, input logic [15:0] d,
                             input bit phy, input bit ign);
        int   p, total, b, idx;
        logic ex_o[$];
        logic ex_oe[$];
        logic om, oo, ooe, ob, od, ee, em;
        logic [15:0] odata, ed;
        p = p0 ? 0 : 32;
        total = (p + 33) * D;
        for (int i = 0; i < p; i++) begin ex_o.push_back(1'b1); ex_oe.push_back(1'b1); end
        ex_o.push_back(1'b0); ex_oe.push_back(1'b1);
        ex_o.push_back(1'b1); ex_oe.push_back(1'b1);
        ex_o.push_back(rd);   ex_oe.push_back(1'b1);
        ex_o.push_back(~rd);  ex_oe.push_back(1'b1);
        for (int i = 4; i >= 0; i--) begin ex_o.push_back(a[i]); ex_oe.push_back(1'b1); end
        for (int i = 4; i >= 0; i--) begin ex_o.push_back(r[i]); ex_oe.push_back(1'b1); end
        if (rd) begin
            ex_o.push_back(1'b1); ex_oe.push_back(1'b0);
            ex_o.push_back(1'b1); ex_oe.push_back(1'b0);
        end else begin
            ex_o.push_back(1'b1); ex_oe.push_back(1'b1);
            ex_o.push_back(1'b0); ex_oe.push_back(1'b1);
        end
        for (int i = 15; i >= 0; i--) begin
            ex_o.push_back(rd ? 1'b1 : d[i]); ex_oe.push_back(~rd);
        end
        ex_o.push_back(1'b1); ex_oe.push_back(1'b0);

        @(negedge clk);
        sel0 = p0; mode = rd; addr = a; rega = r; wdata = d; start = 1'b1; mdio_i = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        mode = 1'($urandom); addr = 5'($urandom); rega = 5'($urandom); wdata = 16'($urandom);

        for (int k = 0; k <= total; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            om    = p0 ? bus0.mdc     : bus.mdc;
            oo    = p0 ? bus0.mdio_o  : bus.mdio_o;
            ooe   = p0 ? bus0.mdio_oe : bus.mdio_oe;
            ob    = p0 ? bus0.busy    : bus.busy;
            od    = p0 ? bus0.done    : bus.done;
            odata = p0 ? bus0.data_o  : bus.data_o;
            ee    = p0 ? bus0.rd_err  : bus.rd_err;
            if (k < total) begin
                b  = k / D;
                em = ((k % D) >= D / 2);
                checks++;
                if ({om, oo, ooe, ob, od} !== {em, ex_o[b], ex_oe[b], 1'b1, 1'b0}) begin
                    errors++;
                    if (errors < 40)
                        $display("FAIL frame k=%0d mdc,o,oe,busy,done got %b%b%b%b%b expected %b%b%b%b%b",
                                 k, om, oo, ooe, ob, od, em, ex_o[b], ex_oe[b], 1'b1, 1'b0);
                end
                idx = 31 + p - b;
                if (rd && phy && b == p + 15)
                    mdio_i = 1'b0;
                else if (rd && phy && b >= p + 16 && b <= p + 31)
                    mdio_i = d[idx];
                else
                    mdio_i = 1'b1;
                if (ign && k == 49) begin start = 1'b1; addr = 5'd7; end
                if (ign && k == 50) start = 1'b0;
            end else begin
                if (p0) begin
                    ed = 16'h0000; em = 1'b0;
                end else begin
                    if (rd && phy) begin model_data = d; model_err = 1'b0; end
                    else if (rd) model_err = 1'b1;
                    else model_err = 1'b0;
                    ed = model_data; em = model_err;
                end
                checks++;
                if ({om, ooe, ob, od, ee, odata} !== {1'b0, 1'b0, 1'b0, 1'b1, em, ed}) begin
                    errors++;
                    $display("FAIL done k=%0d mdc,oe,busy,done,rd_err,data got %b%b%b%b%b %h expected 0001%b %h",
                             k, om, ooe, ob, od, ee, odata, em, ed);
                end
            end
        end
        mdio_i = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; sel0 = 1'b0; mdio_i = 1'b1;
        mode = 1'b0; addr = '0; rega = '0; wdata = '0;
        model_data = 16'h0000; model_err = 1'b0;
        #12;
        checks++;
        if ({bus.mdc, bus.mdio_o, bus.mdio_oe, bus.busy, bus.done, bus.rd_err, bus.data_o} !==
            {6'b010000, 16'h0000}) begin
            errors++;
            $display("FAIL reset_state got %b%b%b%b%b%b %h expected 010000 0000", bus.mdc, bus.mdio_o,
                     bus.mdio_oe, bus.busy, bus.done, bus.rd_err, bus.data_o);
        end
        checks++;
        if ({bus0.mdc, bus0.mdio_o, bus0.mdio_oe, bus0.busy, bus0.done, bus0.rd_err, bus0.data_o} !==
            {6'b010000, 16'h0000}) begin
            errors++;
            $display("FAIL reset_state_p0 got %b%b%b%b%b%b %h expected 010000 0000", bus0.mdc,
                     bus0.mdio_o, bus0.mdio_oe, bus0.busy, bus0.done, bus0.rd_err, bus0.data_o);
        end
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({bus.busy, bus.mdc, bus.mdio_oe} !== 3'b000) begin
                errors++;
                $display("FAIL idle_after_reset cycle %0d busy,mdc,oe got %b%b%b expected 000",
                         i, bus.busy, bus.mdc, bus.mdio_oe);
            end
        end
    endtask

    task automatic test_write;
        run_frame(1'b0, 1'b0, 5'd1, 5'd0, 16'h1200, 1'b0, 1'b0);
    endtask

    task automatic test_read;
        run_frame(1'b0, 1'b1, 5'd1, 5'd1, 16'h796D, 1'b1, 1'b0);
    endtask

    task automatic test_read_no_phy;
        run_frame(1'b0, 1'b1, 5'd1, 5'd1, 16'hFFFF, 1'b0, 1'b0);
    endtask

    task automatic test_ignored_start;
        run_frame(1'b0, 1'b0, 5'd1, 5'd0, 16'h3C5A, 1'b0, 1'b1);
    endtask

    task automatic test_random;
        for (int i = 0; i < 6; i++)
            run_frame(1'b0, 1'($urandom), 5'($urandom), 5'($urandom), 16'($urandom),
                      1'($urandom_range(0, 3) != 0), 1'b0);
    endtask

    task automatic test_back_to_back;
        run_frame(1'b0, 1'b1, 5'd2, 5'd3, 16'hBEEF, 1'b1, 1'b0);
        run_frame(1'b0, 1'b0, 5'd2, 5'd3, 16'h0F0F, 1'b0, 1'b0);
    endtask

    task automatic test_mid_reset;
        @(negedge clk);
        sel0 = 1'b0; mode = 1'b0; addr = 5'd3; rega = 5'd4; wdata = 16'hA5C3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat ((32 + 21) * D + D / 2) @(posedge clk);
        #2;
        checks++;
        if ({bus.mdc, bus.mdio_oe, bus.busy} !== 3'b111) begin
            errors++;
            $display("FAIL mid_frame_pre mdc,oe,busy got %b%b%b expected 111",
                     bus.mdc, bus.mdio_oe, bus.busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.mdc, bus.mdio_o, bus.mdio_oe, bus.busy, bus.done, bus.rd_err, bus.data_o} !==
            {6'b010000, 16'h0000}) begin
            errors++;
            $display("FAIL mid_frame_reset got %b%b%b%b%b%b %h expected 010000 0000", bus.mdc,
                     bus.mdio_o, bus.mdio_oe, bus.busy, bus.done, bus.rd_err, bus.data_o);
        end
        model_data = 16'h0000; model_err = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        run_frame(1'b0, 1'b0, 5'd9, 5'd17, 16'h8001, 1'b0, 1'b0);
    endtask

    task automatic test_no_preamble;
        run_frame(1'b1, 1'b0, 5'd1, 5'd0, 16'h1200, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset;
        test_write;
        test_read;
        test_read_no_phy;
        test_ignored_start;
        test_random;
        test_back_to_back;
        test_mid_reset;
        test_no_preamble;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
